sram_bridge: RTL and testbench

- Synchronous bridge from a DATA_W-bit CPU load/store port to an external asynchronous SRAM of SRAM_DW bits, such as the 128K x 16 data RAM.
- Each CPU word is split into DATA_W/SRAM_DW SRAM beats.
- The bridge generates CS1/CS2/OE/WE/byte-enable timing with a programmable number of strobe cycles.
- It sits between the core's data-memory port and the board-level SRAM pins, on one clock domain.

---
 rtl/sram_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_sram_bridge.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bridge.sv
// sram_bridge: synchronous bridge from a DATA_W-bit CPU load/store port to an
// external asynchronous SRAM with SRAM_DW-bit data. Each CPU word is split into
// DATA_W/SRAM_DW beats. Each beat runs SETUP, STROBE (WAIT_CYC cycles) and HOLD.
// The transaction then closes with a one-cycle DONE that pulses ack.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   req, we       - CPU request (held until ack) and write flag
//   addr          - CPU byte address
//   wdata, be     - write data (little-endian) and byte enables
//   ack, rdata    - completion pulse and read data (held until the next read ack)
//   sram_cs1_n, sram_cs2, sram_oe_n, sram_we_n, sram_be_n, sram_a
//                 - SRAM control, byte-lane and address pins (all registered)
//   sram_dq_o, sram_dq_oe, sram_dq_i
//                 - split bidirectional data pad
//
// Optional build macro SRAM_BRIDGE_ALIGN_CHK_EN adds output err.
//   With it: a request whose addr is not CPU-word aligned completes immediately
//   with ack+err and no SRAM cycle.
//   Without it: the low address bits are ignored and the access is aligned down.

module sram_bridge #(
    parameter int DATA_W   = 32,
    parameter int SRAM_DW  = 16,
    parameter int ADDR_W   = 17,
    parameter int WAIT_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic                  ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  sram_cs1_n,
    output logic                  sram_cs2,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [SRAM_DW/8-1:0]  sram_be_n,
    output logic [ADDR_W-1:0]     sram_a,
    output logic [SRAM_DW-1:0]    sram_dq_o,
    output logic                  sram_dq_oe,
    input  logic [SRAM_DW-1:0]    sram_dq_i
`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
    ,
    output logic                  err
`endif
);

    localparam int BEATS  = DATA_W / SRAM_DW;
    localparam int LANES  = SRAM_DW / 8;
    localparam int AOFF   = $clog2(LANES);
    localparam int WOFF   = $clog2(DATA_W / 8);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WAIT_CYC - 1);
    localparam logic [31:0]       WORD_MASK = (32'd1 << WOFF) - 32'd1;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    state_t              state, state_d;
    logic [BEAT_W-1:0]   beat, beat_d;
    logic [CNT_W-1:0]    cnt, cnt_d;

    // Transaction captured at acceptance
    logic                txn_we;
    logic [ADDR_W-1:0]   txn_base;
    logic [DATA_W-1:0]   txn_wdata;
    logic [DATA_W/8-1:0] txn_be;

    // The output registers are loaded from the next state. On the accepting
    // edge the latched copy is not valid yet, so the live inputs are used.
    logic                accept;
    logic [31:0]         addr_al;
    logic                cur_we;
    logic [ADDR_W-1:0]   cur_base;
    logic [DATA_W-1:0]   cur_wdata;
    logic [DATA_W/8-1:0] cur_be;

    logic                cs_act;
    logic                oe_n_d, we_n_d, dq_oe_d, ack_d;
    logic [LANES-1:0]    be_n_d;
    logic [ADDR_W-1:0]   a_d;
    logic [SRAM_DW-1:0]  dq_o_d;

    logic                unused_addr_bits;

    assign accept           = (state == IDLE) && req;
    assign addr_al          = addr & ~WORD_MASK;
    assign unused_addr_bits = ^addr;

    assign cur_we    = accept ? we                      : txn_we;
    assign cur_base  = accept ? addr_al[AOFF +: ADDR_W] : txn_base;
    assign cur_wdata = accept ? wdata                   : txn_wdata;
    assign cur_be    = accept ? be                      : txn_be;

`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
    logic misaligned;
    assign misaligned = |(addr & WORD_MASK);
`endif

    always_comb begin
        state_d = state;
        beat_d  = beat;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    beat_d = '0;
                    cnt_d  = '0;
`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
                    state_d = misaligned ? DONE : SETUP;
`else
                    state_d = SETUP;
`endif
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt == LAST_CNT) state_d = HOLD;
                else                 cnt_d   = cnt + CNT_W'(1);
            end
            HOLD: begin
                if (beat == LAST_BEAT) begin
                    state_d = DONE;
                end else begin
                    beat_d  = beat + BEAT_W'(1);
                    state_d = SETUP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values for the cycle that state_d describes
        cs_act  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        oe_n_d  = !((state_d == STROBE) && !cur_we);
        we_n_d  = !((state_d == STROBE) && cur_we);
        dq_oe_d = cs_act && cur_we;
        ack_d   = (state_d == DONE);
        be_n_d  = '1;
        if (cs_act) be_n_d = cur_we ? ~cur_be[beat_d*LANES +: LANES] : '0;
        a_d    = sram_a;
        dq_o_d = sram_dq_o;
        if (state_d == SETUP) begin
            a_d = cur_base + ADDR_W'(beat_d);
            if (cur_we) dq_o_d = cur_wdata[beat_d*SRAM_DW +: SRAM_DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            cnt        <= '0;
            sram_cs1_n <= 1'b1;
            sram_cs2   <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= '1;
            sram_a     <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            ack        <= 1'b0;
            rdata      <= '0;
        end else begin
            state      <= state_d;
            beat       <= beat_d;
            cnt        <= cnt_d;
            sram_cs1_n <= !cs_act;
            sram_cs2   <= cs_act;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_be_n  <= be_n_d;
            sram_a     <= a_d;
            sram_dq_o  <= dq_o_d;
            sram_dq_oe <= dq_oe_d;
            ack        <= ack_d;
            // Sample the pad at the end of the last OE strobe cycle
            if ((state == STROBE) && (cnt == LAST_CNT) && !txn_we)
                rdata[beat*SRAM_DW +: SRAM_DW] <= sram_dq_i;
        end
    end

`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
    // Only the misaligned path goes straight from IDLE to DONE
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= (state == IDLE) && (state_d == DONE);
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            txn_we    <= we;
            txn_base  <= addr_al[AOFF +: ADDR_W];
            txn_wdata <= wdata;
            txn_be    <= be;
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
module tb_sram_bridge;

    localparam int DATA_W   = 32;
    localparam int SRAM_DW  = 16;
    localparam int ADDR_W   = 17;
    localparam int WAIT_CYC = 2;
    localparam int BE_W     = DATA_W / 8;
    localparam int BEATS    = DATA_W / SRAM_DW;
    localparam int LANES    = SRAM_DW / 8;
    localparam int AOFF     = $clog2(LANES);
    localparam int PHASES   = WAIT_CYC + 2;
    localparam int LAT      = BEATS * PHASES + 1;
    localparam int BYTE_AW  = ADDR_W + AOFF;

    logic                clk, rst, req, we;
    logic [31:0]         addr;
    logic [DATA_W-1:0]   wdata;
    logic [BE_W-1:0]     be;
    logic                ack;
    logic [DATA_W-1:0]   rdata;
    logic                sram_cs1_n, sram_cs2, sram_oe_n, sram_we_n, sram_dq_oe;
    logic [LANES-1:0]    sram_be_n;
    logic [ADDR_W-1:0]   sram_a;
    logic [SRAM_DW-1:0]  sram_dq_o, sram_dq_i;
`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
    logic                err;
    logic                ack_err;
`endif

    sram_bridge #(
        .DATA_W(DATA_W), .SRAM_DW(SRAM_DW), .ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ack(ack), .rdata(rdata),
        .sram_cs1_n(sram_cs1_n), .sram_cs2(sram_cs2), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n), .sram_a(sram_a),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
        , .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pin-level SRAM model and byte-addressed reference memory
    bit [SRAM_DW-1:0] sram_mem [1 << ADDR_W];
    bit [7:0]         ref_mem  [1 << BYTE_AW];
    logic [DATA_W-1:0] exp_rdata;

    assign sram_dq_i = (!sram_cs1_n && sram_cs2 && !sram_oe_n) ? sram_mem[sram_a] : 16'hA5A5;

    always @(negedge clk) begin
        if (!sram_cs1_n && sram_cs2 && !sram_we_n)
            for (int l = 0; l < LANES; l++)
                if (!sram_be_n[l]) sram_mem[sram_a][l*8 +: 8] = sram_dq_o[l*8 +: 8];
        checks++;
        if (!sram_oe_n && !sram_we_n) begin
            errors++;
            $display("FAIL strobe_overlap: oe_n=%b we_n=%b, required not both 0", sram_oe_n, sram_we_n);
        end
        checks++;
        if (sram_dq_oe && !(!sram_cs1_n && sram_cs2 && sram_oe_n)) begin
            errors++;
            $display("FAIL dq_oe_window: dq_oe=1 with cs1_n=%b cs2=%b oe_n=%b", sram_cs1_n, sram_cs2, sram_oe_n);
        end
    end

    function automatic logic [BYTE_AW-1:0] byte_slot(input logic [31:0] a, input int i);
        logic [31:0] s;
        s = a + 32'(i);
        return s[BYTE_AW-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] exp_word(input logic [31:0] a, input int k);
        logic [31:0] s;
        s = a + 32'(k * LANES);
        return s[AOFF +: ADDR_W];
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [DATA_W-1:0] d,
                             input logic [BE_W-1:0] b, input int nbytes);
        for (int i = 0; i < nbytes; i++)
            if (b[i]) ref_mem[byte_slot(a, i)] = d[i*8 +: 8];
    endtask

    function automatic logic [DATA_W-1:0] ref_read(input logic [31:0] a);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < BE_W; i++) r[i*8 +: 8] = ref_mem[byte_slot(a, i)];
        return r;
    endfunction

    // Per-cycle pin log of the most recent transaction, cycle 1 = after acceptance
    logic [ADDR_W-1:0]  log_a    [64];
    logic [LANES-1:0]   log_be   [64];
    logic [1:0]         log_cs   [64];
    logic               log_we_n [64];
    logic               log_oe_n [64];
    logic               log_dqoe [64];
    logic [SRAM_DW-1:0] log_dq   [64];
    int                 ack_cyc;
    logic [DATA_W-1:0]  ack_rdata;

    task automatic run_txn(input logic w, input logic [31:0] a,
                           input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        ack_cyc = -1;
        for (int c = 1; c < 64 && ack_cyc < 0; c++) begin
            @(negedge clk);
            // Scramble inputs: the bridge must work from its latched copy
            req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = BE_W'($urandom);
            log_a[c] = sram_a;  log_be[c] = sram_be_n; log_cs[c] = {sram_cs1_n, sram_cs2};
            log_we_n[c] = sram_we_n; log_oe_n[c] = sram_oe_n;
            log_dqoe[c] = sram_dq_oe; log_dq[c] = sram_dq_o;
            if (ack) begin
                ack_cyc = c;
                ack_rdata = rdata;
`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
                ack_err = err;
`endif
            end
        end
        checks++;
        if (ack_cyc < 0) begin
            errors++;
            $display("FAIL ack_timeout: no ack within 63 cycles, required ack");
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sram_cs1_n, sram_cs2, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe, ack} !==
            {1'b1, 1'b0, 1'b1, 1'b1, {LANES{1'b1}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: cs1_n=%b cs2=%b oe_n=%b we_n=%b be_n=%b dq_oe=%b ack=%b, required 1 0 1 1 11 0 0",
                     sram_cs1_n, sram_cs2, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe, ack);
        end
        checks++;
        if (sram_a !== '0 || sram_dq_o !== '0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: a=%h dq_o=%h rdata=%h, required 0", sram_a, sram_dq_o, rdata);
        end
        rst = 1'b0;
        exp_rdata = '0;
    endtask

    task automatic test_write_read;
        int nlow;
        run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        ref_write(32'h10, 32'hDEAD_BEEF, 4'hF, BE_W);
        checks++;
        if (ack_cyc !== LAT) begin
            errors++; $display("FAIL wr_latency: ack at cycle %0d, required %0d", ack_cyc, LAT);
        end
        checks++;
        if ({log_a[1], log_dq[1], log_dqoe[1], log_be[1], log_cs[1]} !== {17'h08, 16'hBEEF, 1'b1, 2'b00, 2'b01}) begin
            errors++;
            $display("FAIL wr_beat0: a=%h dq=%h dq_oe=%b be_n=%b cs=%b, required 08 beef 1 00 01",
                     log_a[1], log_dq[1], log_dqoe[1], log_be[1], log_cs[1]);
        end
        checks++;
        if ({log_a[PHASES+1], log_dq[PHASES+1]} !== {17'h09, 16'hDEAD}) begin
            errors++;
            $display("FAIL wr_beat1: a=%h dq=%h, required 09 dead", log_a[PHASES+1], log_dq[PHASES+1]);
        end
        nlow = 0;
        for (int c = 1; c < LAT; c++) if (log_we_n[c] === 1'b0) nlow++;
        checks++;
        if (nlow !== BEATS * WAIT_CYC || log_we_n[1] !== 1'b1 || log_we_n[2] !== 1'b0 || log_we_n[PHASES] !== 1'b1) begin
            errors++;
            $display("FAIL wr_we_pulse: %0d low cycles, required %0d at strobe cycles", nlow, BEATS * WAIT_CYC);
        end
        run_txn(1'b0, 32'h10, $urandom, BE_W'($urandom));
        exp_rdata = 32'hDEAD_BEEF;
        checks++;
        if (ack_cyc !== LAT || ack_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_basic: ack cycle %0d rdata %h, required %0d deadbeef", ack_cyc, ack_rdata, LAT);
        end
        nlow = 0;
        for (int c = 1; c < LAT; c++) if (log_oe_n[c] === 1'b0) nlow++;
        checks++;
        if (nlow !== BEATS * WAIT_CYC) begin
            errors++; $display("FAIL rd_oe_pulse: %0d low cycles, required %0d", nlow, BEATS * WAIT_CYC);
        end
    endtask

    task automatic test_partial_write;
        run_txn(1'b1, 32'h10, 32'h1122_3344, 4'h6);
        ref_write(32'h10, 32'h1122_3344, 4'h6, BE_W);
        checks++;
        if (log_be[1] !== 2'b01 || log_be[PHASES+1] !== 2'b10) begin
            errors++;
            $display("FAIL partial_be_n: beat0 %b beat1 %b, required 01 10", log_be[1], log_be[PHASES+1]);
        end
        run_txn(1'b0, 32'h10, $urandom, BE_W'($urandom));
        exp_rdata = 32'hDE22_33EF;
        checks++;
        if (ack_rdata !== 32'hDE22_33EF) begin
            errors++; $display("FAIL partial_readback: got %h, required de2233ef", ack_rdata);
        end
    endtask

    task automatic test_addr_wrap;
        logic [DATA_W-1:0] d1, d2, exp;
        d1 = $urandom; d2 = $urandom;
        run_txn(1'b1, 32'h0003_FFFC, d1, 4'hF);
        ref_write(32'h0003_FFFC, d1, 4'hF, BE_W);
        checks++;
        if (log_a[1] !== 17'h1FFFE || log_a[PHASES+1] !== 17'h1FFFF) begin
            errors++;
            $display("FAIL wrap_top: a %h %h, required 1fffe 1ffff", log_a[1], log_a[PHASES+1]);
        end
        run_txn(1'b1, 32'h0004_0000, d2, 4'hF);
        ref_write(32'h0004_0000, d2, 4'hF, BE_W);
        checks++;
        if (log_a[1] !== 17'h00000 || log_a[PHASES+1] !== 17'h00001) begin
            errors++;
            $display("FAIL wrap_zero: a %h %h, required 00000 00001", log_a[1], log_a[PHASES+1]);
        end
        exp = ref_read(32'h0003_FFFC);
        run_txn(1'b0, 32'h0003_FFFC, $urandom, BE_W'($urandom));
        exp_rdata = exp;
        checks++;
        if (ack_rdata !== exp) begin
            errors++; $display("FAIL wrap_read_top: got %h, required %h", ack_rdata, exp);
        end
        exp = ref_read(32'h0);
        run_txn(1'b0, 32'h0, $urandom, BE_W'($urandom));
        exp_rdata = exp;
        checks++;
        if (ack_rdata !== d2) begin
            errors++; $display("FAIL wrap_alias: got %h, required %h", ack_rdata, d2);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a1, a2;
        logic [DATA_W-1:0] e1, e2, r1, r2;
        int n, first, second;
        a1 = 32'(4 * $urandom_range(0, 15));
        a2 = 32'h0003_FFFC;
        e1 = ref_read(a1); e2 = ref_read(a2);
        r1 = '0; r2 = '0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a1; be = BE_W'($urandom);
        @(posedge clk);
        n = 0; first = -1; second = -1;
        for (int c = 1; c <= 2 * LAT + 8; c++) begin
            @(negedge clk);
            if (ack) begin
                n++;
                if (first < 0) begin first = c; r1 = rdata; end
                else if (second < 0) begin second = c; r2 = rdata; end
            end
            if (c == LAT) addr = a2;
            if (c == 2 * LAT + 1) req = 1'b0;
        end
        exp_rdata = e2;
        checks++;
        if (n !== 2 || first !== LAT || second !== 2 * LAT + 1) begin
            errors++;
            $display("FAIL b2b_acks: %0d acks at %0d,%0d, required 2 at %0d,%0d", n, first, second, LAT, 2 * LAT + 1);
        end
        checks++;
        if (r1 !== e1 || r2 !== e2) begin
            errors++; $display("FAIL b2b_rdata: got %h %h, required %h %h", r1, r2, e1, e2);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic w;
            logic [31:0] a;
            logic [DATA_W-1:0] d, exp;
            logic [LANES-1:0] exp_be;
            logic strobe;
            int bad, k, ph;
            w = 1'($urandom); d = $urandom; b_rand: begin end
            if ($urandom_range(0, 3) == 0) a = 32'h0003_FFF0 + 32'(4 * $urandom_range(0, 3));
            else                           a = 32'(4 * $urandom_range(0, 15));
            a = a + {8'($urandom_range(0, 3)), 24'h0};
            be = BE_W'($urandom);
            exp = ref_read(a);
            begin
                logic [BE_W-1:0] b;
                b = be;
                run_txn(w, a, d, b);
                if (w) ref_write(a, d, b, BE_W);
                else   exp_rdata = exp;
                bad = 0;
                for (int c = 1; c < LAT; c++) begin
                    k = (c - 1) / PHASES;
                    ph = (c - 1) % PHASES;
                    strobe = (ph >= 1) && (ph <= WAIT_CYC);
                    exp_be = w ? ~b[k*LANES +: LANES] : '0;
                    if (log_cs[c] !== 2'b01 || log_a[c] !== exp_word(a, k) || log_be[c] !== exp_be ||
                        log_we_n[c] !== !(w && strobe) || log_oe_n[c] !== !(!w && strobe) ||
                        log_dqoe[c] !== w || (w && log_dq[c] !== d[k*SRAM_DW +: SRAM_DW]))
                        bad++;
                end
                if (log_cs[LAT] !== 2'b10 || log_be[LAT] !== {LANES{1'b1}} || log_dqoe[LAT] !== 1'b0 ||
                    log_we_n[LAT] !== 1'b1 || log_oe_n[LAT] !== 1'b1)
                    bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL rand_pins: txn %0d we=%b addr=%h has %0d bad cycles, required 0", n, w, a, bad);
            end
            checks++;
            if (ack_cyc !== LAT) begin
                errors++; $display("FAIL rand_latency: txn %0d ack at %0d, required %0d", n, ack_cyc, LAT);
            end
            checks++;
            if (ack_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rand_rdata: txn %0d we=%b addr=%h got %h, required %h", n, w, a, ack_rdata, exp_rdata);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] a;
        logic [DATA_W-1:0] d, exp;
        int nack;
        a = 32'(4 * $urandom_range(16, 31));
        d = $urandom;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; be = '1;
        @(posedge clk);
        for (int c = 1; c <= PHASES + 1; c++) begin
            @(negedge clk);
            req = 1'b0;
        end
        // First beat fully strobed, second beat only in SETUP
        rst = 1'b1;
        nack = 0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            if (ack) nack++;
            checks++;
            if ({sram_cs1_n, sram_cs2, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe} !==
                {1'b1, 1'b0, 1'b1, 1'b1, {LANES{1'b1}}, 1'b0} || sram_a !== '0 || sram_dq_o !== '0 || rdata !== '0) begin
                errors++;
                $display("FAIL midrst_values: cycle %0d cs1_n=%b cs2=%b oe_n=%b we_n=%b be_n=%b dq_oe=%b a=%h dq=%h rdata=%h, required reset values",
                         r, sram_cs1_n, sram_cs2, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe, sram_a, sram_dq_o, rdata);
            end
        end
        rst = 1'b0;
        exp_rdata = '0;
        checks++;
        if (nack !== 0) begin
            errors++; $display("FAIL midrst_ack: %0d acks during reset, required 0", nack);
        end
        ref_write(a, d, '1, LANES);
        exp = ref_read(a);
        run_txn(1'b0, a, $urandom, BE_W'($urandom));
        exp_rdata = exp;
        checks++;
        if (ack_cyc !== LAT || ack_rdata !== exp) begin
            errors++;
            $display("FAIL midrst_readback: ack %0d rdata %h, required %0d %h", ack_cyc, ack_rdata, LAT, exp);
        end
    endtask

`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
    task automatic test_align;
        logic [DATA_W-1:0] exp;
        run_txn(1'b0, 32'h12, $urandom, BE_W'($urandom));
        checks++;
        if (ack_cyc !== 1 || ack_err !== 1'b1 || log_cs[1] !== 2'b10 || ack_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL align_err: ack %0d err %b cs %b rdata %h, required 1 1 10 %h",
                     ack_cyc, ack_err, log_cs[1], ack_rdata, exp_rdata);
        end
        exp = ref_read(32'h10);
        run_txn(1'b0, 32'h10, $urandom, BE_W'($urandom));
        exp_rdata = exp;
        checks++;
        if (ack_cyc !== LAT || ack_err !== 1'b0 || ack_rdata !== exp) begin
            errors++;
            $display("FAIL align_ok: ack %0d err %b rdata %h, required %0d 0 %h", ack_cyc, ack_err, ack_rdata, LAT, exp);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        exp_rdata = '0;
        test_reset;
        test_write_read;
        test_partial_write;
        test_addr_wrap;
        test_back_to_back;
        test_random;
        test_reset_mid;
`ifdef SRAM_BRIDGE_ALIGN_CHK_EN
        test_align;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

endmodule
